// File: rtl/strobe_flash_out.sv
// Flash/trigger output stage: delays the filtered strobe, shapes it to a fixed or
// strobe-following width, applies polarity and keeps pulse count / overrun status.
module strobe_flash_out #(
    parameter int DELAY_WIDTH = 16,
    parameter int PW_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_acquisition_start,
    input  logic                   i_stream_enable,
    input  logic                   i_output_en,
    input  logic                   i_strobe,
    input  logic [DELAY_WIDTH-1:0] iv_delay,
    input  logic [PW_WIDTH-1:0]    iv_pulse_width,
    input  logic                   i_polarity,
    output logic                   o_flash,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic [15:0]            ov_pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [DELAY_WIDTH-1:0] DLY_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW_WIDTH-1:0]    PW_ONE  = {{(PW_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW_WIDTH-1:0]    PW_MAX  = {PW_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic                   enable_q;
    logic                   strobe_q;
    logic                   rise;
    logic                   active_done;
    logic [DELAY_WIDTH-1:0] dly_reg_q, dly_reg_d;
    logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
    logic [PW_WIDTH-1:0]    pw_reg_q, pw_reg_d;
    logic [PW_WIDTH-1:0]    act_cnt_q, act_cnt_d;
    logic [PW_WIDTH-1:0]    len_cnt_q, len_cnt_d;
    logic                   low_seen_q, low_seen_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            pulse_cnt_q, pulse_cnt_d;
    logic                   flash_q;

    assign rise = i_strobe & ~strobe_q;

    // Follow mode ends once the strobe has gone low (this sample or earlier) and
    // the output has been active for as many cycles as the strobe was high.
    always_comb begin
        active_done = 1'b0;
        if (pw_reg_q != '0) begin
            active_done = (act_cnt_q == pw_reg_q);
        end else begin
            active_done = (low_seen_q | ~i_strobe) && (act_cnt_q == len_cnt_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        dly_reg_d   = dly_reg_q;
        pw_reg_d    = pw_reg_q;
        dly_cnt_d   = dly_cnt_q;
        act_cnt_d   = act_cnt_q;
        len_cnt_d   = len_cnt_q;
        low_seen_d  = low_seen_q;
        overrun_d   = overrun_q;
        pulse_cnt_d = pulse_cnt_q;

        if (state_q != S_IDLE && !low_seen_q) begin
            if (i_strobe) begin
                len_cnt_d = (len_cnt_q == PW_MAX) ? len_cnt_q : len_cnt_q + PW_ONE;
            end else begin
                low_seen_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rise && enable_q) begin
                    dly_reg_d   = iv_delay;
                    pw_reg_d    = iv_pulse_width;
                    pulse_cnt_d = pulse_cnt_q + 16'd1;
                    len_cnt_d   = PW_ONE;
                    low_seen_d  = 1'b0;
                    if (iv_delay == '0) begin
                        state_d   = S_ACTIVE;
                        dly_cnt_d = '0;
                        act_cnt_d = PW_ONE;
                    end else begin
                        state_d   = S_DELAY;
                        dly_cnt_d = DLY_ONE;
                        act_cnt_d = '0;
                    end
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == dly_reg_q) begin
                    state_d   = S_ACTIVE;
                    act_cnt_d = PW_ONE;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_ONE;
                end
            end
            S_ACTIVE: begin
                if (active_done) begin
                    state_d    = S_IDLE;
                    dly_cnt_d  = '0;
                    act_cnt_d  = '0;
                    len_cnt_d  = '0;
                    low_seen_d = 1'b0;
                end else begin
                    act_cnt_d = (act_cnt_q == PW_MAX) ? act_cnt_q : act_cnt_q + PW_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A rise while busy never retriggers; it is only recorded.
        if (state_q != S_IDLE && rise) begin
            overrun_d = 1'b1;
        end

        if (!enable_q) begin
            state_d    = S_IDLE;
            dly_cnt_d  = '0;
            act_cnt_d  = '0;
            len_cnt_d  = '0;
            low_seen_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            strobe_q    <= 1'b0;
            dly_reg_q   <= '0;
            pw_reg_q    <= '0;
            dly_cnt_q   <= '0;
            act_cnt_q   <= '0;
            len_cnt_q   <= '0;
            low_seen_q  <= 1'b0;
            overrun_q   <= 1'b0;
            pulse_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= i_acquisition_start & i_stream_enable & i_output_en;
            strobe_q    <= i_strobe;
            dly_reg_q   <= dly_reg_d;
            pw_reg_q    <= pw_reg_d;
            dly_cnt_q   <= dly_cnt_d;
            act_cnt_q   <= act_cnt_d;
            len_cnt_q   <= len_cnt_d;
            low_seen_q  <= low_seen_d;
            overrun_q   <= overrun_d;
            pulse_cnt_q <= pulse_cnt_d;
            flash_q     <= (state_d == S_ACTIVE) ^ i_polarity;
        end
    end

    assign o_flash      = flash_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_overrun    = overrun_q;
    assign ov_pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/strobe_flash_out.md
Name: strobe_flash_out

Overview:
- Output stage directly downstream of the sensor strobe filter.
- Consumes the filtered, clk-synchronous strobe and drives the external flash/trigger-out line.
- Adds programmable delay, programmable or strobe-following pulse width, and polarity.
- Provides an accepted-pulse counter and an overrun flag for register readback.

Parameters:
DELAY_WIDTH, 16, width of delay register and delay counter
PW_WIDTH, 16, width of pulse-width register, width counter and strobe-length counter

Ports:
clk  input  1  pixel-domain clock, 72 MHz
reset_n  input  1  asynchronous active-low reset
i_acquisition_start  input  1  0 = stop, 1 = acquire
i_stream_enable  input  1  0 = stop, 1 = stream
i_output_en  input  1  flash output enable register bit
i_strobe  input  1  filtered strobe, synchronous to clk, active high
iv_delay  input  DELAY_WIDTH  delay in clk cycles from strobe rise to flash assert
iv_pulse_width  input  PW_WIDTH  flash width in clk cycles; 0 = follow strobe length
i_polarity  input  1  0 = active-high output, 1 = active-low output
o_flash  output  1  flash/trigger line
o_busy  output  1  1 while state is DELAY or ACTIVE
o_overrun  output  1  sticky: strobe rise arrived while busy
ov_pulse_cnt  output  16  count of accepted strobe pulses

Behaviour:
- Async reset (reset_n=0):
  - State = IDLE; all counters = 0; enable_r = 0.
  - o_flash = 0, o_busy = 0, o_overrun = 0, ov_pulse_cnt = 0.
  - The polarity level is not applied during reset.
- Enable:
  - enable_r <= i_acquisition_start & i_stream_enable & i_output_en, registered (1-cycle latency).
- Rise detect:
  - strobe_d <= i_strobe; rise = i_strobe & ~strobe_d.
- State IDLE:
  - On rise & enable_r: latch iv_delay → dly_reg and iv_pulse_width → pw_reg; ov_pulse_cnt++ (16-bit wrap).
  - If dly_reg = 0, go to ACTIVE; otherwise go to DELAY with dly_cnt = 1.
  - Later register writes do not affect a pulse in progress.
- State DELAY:
  - dly_cnt++ each cycle.
  - When dly_cnt = dly_reg, go to ACTIVE.
- State ACTIVE:
  - Fixed mode (pw_reg ≠ 0): o_flash is active for exactly pw_reg cycles, then IDLE.
  - Follow mode (pw_reg = 0):
    - len_cnt counts the cycles i_strobe is high, from the accepted rise to the first low sample. It saturates at all-ones.
    - ACTIVE ends once the strobe low has been sampled and the active-cycle count equals len_cnt.
    - Result: the output width equals the strobe width, delayed by dly_reg.
- Timing:
  - i_strobe sampled high at edge k, low at edge k-1.
  - o_flash is active after edge k+D and inactive after edge k+D+W.
  - W = pw_reg, or the strobe high length in follow mode.
- Output:
  - o_flash <= (state_next = ACTIVE) ^ i_polarity, registered.
  - When idle and not in reset, o_flash = i_polarity.
- Status:
  - o_busy = (state ≠ IDLE), combinational from the state register.
- Overrun:
  - A rise while busy is ignored (no retrigger, no count) and sets o_overrun.
  - o_overrun clears when enable_r = 0.
- Enable drop mid-pulse:
  - enable_r = 0 forces IDLE on the next edge; o_flash returns to the inactive level on that edge.
  - Counters are cleared; ov_pulse_cnt is held.
- Edge cases:
  - A rise in the same cycle the FSM returns to IDLE is not accepted.
  - A rise on the cycle after return is accepted.
  - A strobe already high when enable rises produces no pulse, because there is no rise.

Test Plan:
- Fixed width: delay=0, width=5, strobe high 3 cycles at edge 10 → o_flash=1 after edges 10..14, 0 after edge 15; ov_pulse_cnt=1.
- Follow mode: delay=4, width=0, strobe high 20 cycles from edge 100 → o_flash high after edges 104..123 (20 cycles); o_busy low after edge 124.
- Polarity and disable: i_polarity=1, i_output_en=0, strobe pulses → o_flash constant 1, ov_pulse_cnt=0; set i_output_en=1 → pulses appear as 0-going.
- Overrun: delay=10, width=10, second strobe rise 6 cycles after the first → single 10-cycle pulse, o_overrun=1, ov_pulse_cnt=1; drop i_stream_enable → o_overrun=0.
- Abort: drop i_acquisition_start 3 cycles into ACTIVE → o_flash inactive 2 edges later (register + FSM), o_busy=0; next rise after re-enable gives a full pulse.
- Async reset: assert reset_n=0 mid-DELAY, between clock edges → o_flash, o_busy, ov_pulse_cnt = 0 immediately.
